// File: rtl/adc_sequencer_pkg.sv
// adc_sequencer_pkg
//   Shared types and helpers for the ADC conversion sequencer:
//   - MAX_BITS      : widest conversion result supported (16-bit DAC state)
//   - state_t       : sequencer FSM states
//   - clamp_*       : map out-of-range phase/bit settings to legal values
package adc_sequencer_pkg;

  localparam int MAX_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SAMP,
    COMP,
    UPDATE
  } state_t;

  // A zero-length sampling phase would never end; treat it as one cycle.
  function automatic logic [7:0] clamp_samp_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

  function automatic logic [3:0] clamp_comp_len(input logic [3:0] len);
    return (len == 4'd0) ? 4'd1 : len;
  endfunction

  // At least one comparison, never more than the result register can hold.
  function automatic logic [4:0] clamp_num_bits(input logic [4:0] n,
                                                input logic [4:0] max_bits);
    if (n == 5'd0) begin
      return 5'd1;
    end
    if (n > max_bits) begin
      return max_bits;
    end
    return n;
  endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// adc_seq_timer
//   Loadable down-counter producing the end-of-phase strobe for the SAMP and
//   COMP phases. Loading value L makes done high L cycles later, i.e. load
//   (length-1) on the edge that enters a phase and done marks its last cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load value into the counter on this edge
//   value     - reload value
//   done      - counter is at zero (current cycle is the last of the phase)
module adc_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer
//   Drives the ADC phase strobes (init / sample / compare / update), collects
//   one comparator decision per SAR step into a shift register and delivers
//   the finished word through a one-entry valid/ready output register.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, continuous        - conversion request / free-running mode
//   samp_len, comp_len       - phase lengths in cycles (0 behaves as 1)
//   num_bits                 - comparisons per conversion (clamped 1..MAX_BITS)
//   seq_init/samp/comp/update- registered one-hot phase outputs to the ADC
//   comp_out                 - comparator decision from the ADC
//   busy                     - any state other than IDLE
//   result, result_valid, result_ready - output register handshake
//   overrun                  - sticky: an unconsumed result was overwritten
module adc_sequencer #(
  parameter int MAX_BITS = adc_sequencer_pkg::MAX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic [7:0]          samp_len,
  input  logic [3:0]          comp_len,
  input  logic [4:0]          num_bits,
  output logic                seq_init,
  output logic                seq_samp,
  output logic                seq_comp,
  output logic                seq_update,
  input  logic                comp_out,
  output logic                busy,
  output logic [MAX_BITS-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overrun
);

  import adc_sequencer_pkg::*;

  state_t              state_reg;
  state_t              state_next;
  logic [7:0]          samp_len_reg;
  logic [3:0]          comp_len_reg;
  logic [4:0]          num_bits_reg;
  logic [4:0]          bit_cnt_reg;
  logic [MAX_BITS-1:0] shift_reg;

  logic                latch_params;
  logic                take_bit;
  logic                conv_done;
  logic                timer_load;
  logic [7:0]          timer_value;
  logic                timer_done;

  adc_seq_timer #(
    .WIDTH(8)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .value(timer_value),
    .done (timer_done)
  );

  always_comb begin
    state_next   = state_reg;
    latch_params = 1'b0;
    take_bit     = 1'b0;
    conv_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = INIT;
          latch_params = 1'b1;
        end
      end
      INIT: state_next = SAMP;
      SAMP: begin
        if (timer_done) begin
          state_next = COMP;
        end
      end
      COMP: begin
        if (timer_done) begin
          state_next = UPDATE;
          take_bit   = 1'b1;
        end
      end
      UPDATE: begin
        if (bit_cnt_reg < num_bits_reg) begin
          state_next = COMP;
        end else begin
          conv_done = 1'b1;
          if (continuous) begin
            state_next   = INIT;
            latch_params = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arm the timer on the edge that enters a timed phase.
  assign timer_load  = (state_next != state_reg) &&
                       ((state_next == SAMP) || (state_next == COMP));
  assign timer_value = (state_next == SAMP) ? (samp_len_reg - 8'd1)
                                            : ({4'd0, comp_len_reg} - 8'd1);

  // Phase outputs are decoded from the next state and registered, so each
  // strobe comes straight from a flop and lines up with the state it names.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      seq_init   <= 1'b0;
      seq_samp   <= 1'b0;
      seq_comp   <= 1'b0;
      seq_update <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      seq_init   <= (state_next == INIT);
      seq_samp   <= (state_next == SAMP);
      seq_comp   <= (state_next == COMP);
      seq_update <= (state_next == UPDATE);
      busy       <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_len_reg <= 8'd1;
      comp_len_reg <= 4'd1;
      num_bits_reg <= 5'd1;
    end else if (latch_params) begin
      samp_len_reg <= clamp_samp_len(samp_len);
      comp_len_reg <= clamp_comp_len(comp_len);
      num_bits_reg <= clamp_num_bits(num_bits, 5'(MAX_BITS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_reg == INIT)) begin
      bit_cnt_reg <= 5'd0;
    end else if (take_bit) begin
      bit_cnt_reg <= bit_cnt_reg + 5'd1;
    end
  end

  // Decisions enter at the LSB and move up; after N shifts the first one
  // sits at bit N-1 and everything above it is still zero from INIT.
  generate
    for (genvar gi = 0; gi < MAX_BITS; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst || (state_reg == INIT)) begin
          shift_reg[gi] <= 1'b0;
        end else if (take_bit) begin
          if (gi == 0) begin
            shift_reg[gi] <= comp_out;
          end else begin
            shift_reg[gi] <= shift_reg[(gi == 0) ? 0 : gi-1];
          end
        end
      end
    end
  endgenerate

  // A load always wins; a handshake in the same cycle simply means the old
  // word was taken, so no overrun is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (conv_done) begin
      result       <= shift_reg;
      result_valid <= 1'b1;
      if (result_valid && !result_ready) begin
        overrun <= 1'b1;
      end
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer
//   Directed bench for adc_sequencer. Cycle 0 is the cycle in which start is
//   driven high; outputs are sampled 1 time unit after each rising edge.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        continuous;
  logic [7:0]  samp_len;
  logic [3:0]  comp_len;
  logic [4:0]  num_bits;
  logic        seq_init;
  logic        seq_samp;
  logic        seq_comp;
  logic        seq_update;
  logic        comp_out;
  logic        busy;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  adc_sequencer #(.MAX_BITS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .samp_len    (samp_len),
    .comp_len    (comp_len),
    .num_bits    (num_bits),
    .seq_init    (seq_init),
    .seq_samp    (seq_samp),
    .seq_comp    (seq_comp),
    .seq_update  (seq_update),
    .comp_out    (comp_out),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " flags"}, {25'd0, seq_init, seq_samp, seq_comp, seq_update,
                          busy, result_valid, overrun}, 32'd0);
    chk({tag, " result"}, {16'd0, result}, 32'd0);
  endtask

  task automatic drain(input string tag);
    result_ready = 1'b1;
    next_cycle();
    result_ready = 1'b0;
    chk({tag, " drained"}, {31'd0, result_valid}, 32'd0);
  endtask

  // Single conversion from IDLE. sl/cl/nb are the raw inputs, s/c/n the
  // effective values they must behave as. Settings are scrambled after the
  // start cycle to show they were latched.
  task automatic conv_check(input string tag, input logic [7:0] sl, input logic [3:0] cl,
                            input logic [4:0] nb, input int s, input int c, input int n,
                            input logic [15:0] pat, input logic [15:0] exp_res);
    int   e, off, k, ph;
    logic ei, es, ec, eu, eb;
    e = 2 + s + n * (c + 1);
    samp_len = sl; comp_len = cl; num_bits = nb;
    continuous = 1'b0; result_ready = 1'b0; comp_out = 1'b0; start = 1'b1;
    for (int cy = 0; cy <= e; cy++) begin
      if (cy > 0) begin
        next_cycle();
        start = 1'b0;
        samp_len = 8'd200; comp_len = 4'd9; num_bits = 5'd3;
      end
      ei = (cy == 1);
      es = (cy >= 2) && (cy <= s + 1);
      ec = 1'b0; eu = 1'b0; comp_out = 1'b0;
      if ((cy >= s + 2) && (cy < e)) begin
        off = cy - (s + 2);
        k   = off / (c + 1);
        ph  = off % (c + 1);
        ec  = (ph < c);
        eu  = (ph == c);
        if (ec) comp_out = pat[n-1-k];
      end
      eb = (cy >= 1) && (cy < e);
      chk($sformatf("%s c%0d phases", tag, cy),
          {27'd0, seq_init, seq_samp, seq_comp, seq_update, busy},
          {27'd0, ei, es, ec, eu, eb});
      chk($sformatf("%s c%0d valid", tag, cy), {31'd0, result_valid}, {31'd0, (cy == e)});
    end
    chk({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
    chk({tag, " overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  // Two back-to-back conversions, S=1 C=1 N=2: first gives 3 (valid in
  // cycle 7, together with seq_init), second gives 0 (valid in cycle 13).
  task automatic cont_check(input string tag, input bit pulse_ready, input logic exp_ovr);
    samp_len = 8'd1; comp_len = 4'd1; num_bits = 5'd2;
    continuous = 1'b1; result_ready = 1'b0; start = 1'b1;
    for (int cy = 0; cy <= 13; cy++) begin
      if (cy > 0) begin
        next_cycle();
        start = 1'b0;
      end
      comp_out     = (cy < 7);
      continuous   = (cy < 8);
      result_ready = pulse_ready && (cy == 12);
      if (cy == 6) begin
        chk({tag, " c6 update"}, {31'd0, seq_update}, 32'd1);
      end
      if (cy == 7) begin
        chk({tag, " c7 init"}, {31'd0, seq_init}, 32'd1);
        chk({tag, " c7 valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, " c7 result"}, {16'd0, result}, 32'd3);
        chk({tag, " c7 overrun"}, {31'd0, overrun}, 32'd0);
      end
      if (cy == 12) begin
        chk({tag, " c12 valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, " c12 overrun"}, {31'd0, overrun}, 32'd0);
      end
      if (cy == 13) begin
        chk({tag, " c13 valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, " c13 result"}, {16'd0, result}, 32'd0);
        chk({tag, " c13 overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
        chk({tag, " c13 busy"}, {31'd0, busy}, 32'd0);
      end
    end
    result_ready = 1'b0;
    continuous   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; comp_out = 1'b0;
    samp_len = 8'd0; comp_len = 4'd0; num_bits = 5'd0; result_ready = 1'b0;
    next_cycle();
    next_cycle();
    chk_all_zero("reset");
    rst = 1'b0;
    next_cycle();

    // 1,0,1,1,0,0,1,0 -> 0xB2, valid in cycle 30
    conv_check("basic", 8'd4, 4'd2, 5'd8, 4, 2, 8, 16'h00B2, 16'h00B2);
    drain("basic");

    // zero settings behave as S=1 C=1 N=1, valid in cycle 5
    conv_check("zeros", 8'd0, 4'd0, 5'd0, 1, 1, 1, 16'h0001, 16'h0001);
    drain("zeros");

    // 20 bits requested -> 16 comparisons
    conv_check("maxbits", 8'd2, 4'd1, 5'd20, 2, 1, 16, 16'hFFFF, 16'hFFFF);
    drain("maxbits");

    cont_check("cont_ovr", 1'b0, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk_all_zero("rst1");

    cont_check("cont_hs", 1'b1, 1'b0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    chk_all_zero("rst2");

    // start during COMP ignored; rst in the third COMP phase (cycles 12,13)
    samp_len = 8'd4; comp_len = 4'd2; num_bits = 5'd8; comp_out = 1'b1; start = 1'b1;
    for (int cy = 0; cy <= 13; cy++) begin
      if (cy > 0) begin
        next_cycle();
        start = 1'b0;
        rst   = 1'b0;
      end
      if (cy == 6) begin
        chk("ign c6 comp", {31'd0, seq_comp}, 32'd1);
        start = 1'b1;
      end
      if (cy == 7) begin
        chk("ign c7 comp", {31'd0, seq_comp}, 32'd1);
        chk("ign c7 init", {31'd0, seq_init}, 32'd0);
      end
      if (cy == 8) begin
        chk("ign c8 update", {31'd0, seq_update}, 32'd1);
        chk("ign c8 init", {31'd0, seq_init}, 32'd0);
      end
      if (cy == 12) begin
        chk("midrst c12 comp", {31'd0, seq_comp}, 32'd1);
        rst = 1'b1;
      end
    end
    chk_all_zero("midrst c13");
    conv_check("post_rst", 8'd4, 4'd2, 5'd8, 4, 2, 8, 16'h005A, 16'h005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
